// File: rtl/acc_datapath.sv
// Accumulator-machine datapath: PC, IR, MDR, ACC, 2-bit ALU and memory steering.
// Optional sticky signed-overflow flag enabled by defining DP_OVERFLOW_FLAG_EN.
module acc_datapath #(
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned DATA_W = ADDR_W + 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              PCWriteCond,
    input  logic              PCWrite,
    input  logic              IorD,
    input  logic              memRead,
    input  logic              memWrite,
    input  logic              IRWrite,
    input  logic              memToAcc,
    input  logic              accWrite,
    input  logic              ALUSrcA,
    input  logic              ALUSrcB,
    input  logic              PCSrc,
    input  logic [1:0]        ALUFunc,
    output logic [2:0]        opcode,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_re,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              acc_zero,
    output logic [DATA_W-1:0] acc_out,
    output logic              acc_ovf
);

    typedef enum logic [1:0] {
        AluAdd = 2'b00,
        AluSub = 2'b01,
        AluAnd = 2'b10,
        AluNot = 2'b11
    } alu_func_e;

    localparam int unsigned Msb = DATA_W - 1;

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [DATA_W-1:0] ir_q;
    logic [DATA_W-1:0] mdr_q;
    logic [DATA_W-1:0] acc_q, acc_d;

    logic [DATA_W-1:0] alu_a, alu_b, alu_result;
    logic              pc_load, mdr_load;
    logic [ADDR_W-1:0] ir_addr;

    assign ir_addr = ir_q[ADDR_W-1:0];

    always_comb begin
        alu_a = ALUSrcA ? acc_q : {{(DATA_W - ADDR_W){1'b0}}, pc_q};
        alu_b = ALUSrcB ? {{(DATA_W - 1){1'b0}}, 1'b1} : mdr_q;
        case (alu_func_e'(ALUFunc))
            AluAdd:  alu_result = alu_a + alu_b;
            AluSub:  alu_result = alu_a - alu_b;
            AluAnd:  alu_result = alu_a & alu_b;
            AluNot:  alu_result = ~alu_a;
            default: alu_result = alu_a + alu_b;
        endcase
    end

    // Conditional load looks at the registered ACC, never at the ALU output.
    always_comb begin
        pc_load  = PCWrite | (PCWriteCond & acc_zero);
        pc_d     = PCSrc ? ir_addr : alu_result[ADDR_W-1:0];
        mdr_load = memRead & IorD & ~IRWrite;
        acc_d    = memToAcc ? mdr_q : alu_result;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q  <= '0;
            ir_q  <= '0;
            mdr_q <= '0;
            acc_q <= '0;
        end else begin
            if (pc_load)  pc_q  <= pc_d;
            if (IRWrite)  ir_q  <= mem_rdata;
            if (mdr_load) mdr_q <= mem_rdata;
            if (accWrite) acc_q <= acc_d;
        end
    end

    assign opcode    = ir_q[DATA_W-1:ADDR_W];
    assign mem_addr  = IorD ? ir_addr : pc_q;
    assign mem_wdata = acc_q;
    assign mem_re    = memRead & ~rst;
    assign mem_we    = memWrite & ~rst;
    assign acc_zero  = (acc_q == '0);
    assign acc_out   = acc_q;

`ifdef DP_OVERFLOW_FLAG_EN
    logic ovf_q;
    logic add_ovf, sub_ovf, ovf_event;

    // Subtract overflow compares the result sign against ACC, the minuend.
    always_comb begin
        add_ovf   = (alu_a[Msb] == alu_b[Msb]) && (alu_result[Msb] != alu_a[Msb]);
        sub_ovf   = (alu_a[Msb] != alu_b[Msb]) && (alu_result[Msb] != acc_q[Msb]);
        ovf_event = accWrite & ~memToAcc &
                    (((ALUFunc == AluAdd) & add_ovf) | ((ALUFunc == AluSub) & sub_ovf));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else if (ovf_event) begin
            ovf_q <= 1'b1;
        end
    end

    assign acc_ovf = ovf_q;
`else
    assign acc_ovf = 1'b0;
`endif

endmodule
